// File: rtl/alu_issue_queue.sv
// Command FIFO + credit-gated issue to a fixed-latency ALU, with a result buffer sized so results are never dropped.
// Optional macro ALU_ISSUE_STATS_EN adds issued_cnt / stall_cnt counters.
module alu_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_A,
  input  logic [3:0] in_B,
  input  logic [1:0] in_op,
  output logic [3:0] alu_A,
  output logic [3:0] alu_B,
  output logic [1:0] alu_op_code,
  input  logic [5:0] alu_C,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] res_C
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [7:0] issued_cnt,
  output logic [7:0] stall_cnt
`endif
);

  localparam int AW        = $clog2(DEPTH);
  localparam int RES_DEPTH = ALU_LAT + 2;
  localparam int RIW       = $clog2(RES_DEPTH);
  localparam int RW        = $clog2(RES_DEPTH + 1);

  logic [9:0]     cmd_mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           cmd_empty, cmd_full, push, issue;

  logic [ALU_LAT:0] vld_p, vld_nxt;
  logic             capture;

  logic [5:0]     res_mem [RES_DEPTH];
  logic [RIW-1:0] res_wr, res_rd;
  logic [RW-1:0]  res_cnt;
  logic [RW-1:0]  used;
  logic           res_pop;

  function automatic logic [RIW-1:0] res_inc(input logic [RIW-1:0] idx);
    return (idx == RIW'(RES_DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign cmd_empty = (wr_ptr == rd_ptr);
  assign cmd_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = !cmd_full;
  assign push      = in_valid && in_ready;

  assign res_valid = (res_cnt != '0);
  assign res_C     = res_mem[res_rd];
  assign res_pop   = res_valid && res_ready;

  // used = in-flight + buffered results; a same-edge pop frees a slot for this issue decision
  assign issue   = !cmd_empty && ((used < RW'(RES_DEPTH)) || res_pop);
  assign capture = vld_p[ALU_LAT];

  always_comb begin
    vld_nxt    = vld_p << 1;
    vld_nxt[0] = issue;
  end

  always_ff @(posedge clk) begin
    if (push) cmd_mem[wr_ptr[AW-1:0]] <= {in_A, in_B, in_op};
  end

  // Stage p0: FIFO pointers, credit count, issue registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      used        <= '0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_op_code <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(issue);
      used   <= used + RW'(issue) - RW'(res_pop);
      if (issue) {alu_A, alu_B, alu_op_code} <= cmd_mem[rd_ptr[AW-1:0]];
    end
  end

  // Stage p1..: in-flight valid bits, result capture on exit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p   <= '0;
      res_wr  <= '0;
      res_rd  <= '0;
      res_cnt <= '0;
      for (int i = 0; i < RES_DEPTH; i++) res_mem[i] <= '0;
    end else begin
      vld_p   <= vld_nxt;
      res_cnt <= res_cnt + RW'(capture) - RW'(res_pop);
      if (capture) begin
        res_mem[res_wr] <= alu_C;
        res_wr          <= res_inc(res_wr);
      end
      if (res_pop) res_rd <= res_inc(res_rd);
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (issue) issued_cnt <= issued_cnt + 8'd1;
      if (in_valid && !in_ready && stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue with a behavioural ALU model; optional checks under ALU_ISSUE_STATS_EN.
module tb_alu_issue_queue;

  localparam int DEPTH     = 4;
  localparam int ALU_LAT   = 1;
  localparam int RES_DEPTH = ALU_LAT + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] in_A, in_B;
  logic [1:0] in_op;
  logic [3:0] alu_A, alu_B;
  logic [1:0] alu_op_code;
  logic [5:0] alu_C;
  logic       res_valid, res_ready;
  logic [5:0] res_C;
`ifdef ALU_ISSUE_STATS_EN
  logic [7:0] issued_cnt, stall_cnt;
`endif

  alu_issue_queue #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_op(in_op),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op_code(alu_op_code),
    .alu_C(alu_C),
    .res_valid(res_valid), .res_ready(res_ready), .res_C(res_C)
`ifdef ALU_ISSUE_STATS_EN
    , .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return {2'b00, a} + {2'b00, b};
      2'd1:    return {2'b00, a} - {2'b00, b};
      2'd2:    return {2'b00, a & b};
      default: return {2'b00, a ^ b};
    endcase
  endfunction

  // Registered ALU: samples operands on an edge, result valid ALU_LAT edges later
  logic [5:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_fn(alu_A, alu_B, alu_op_code);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_C = alu_pipe[ALU_LAT-1];

  logic [5:0] sb[$];
  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int mcyc = 0;
  int last_pop_cyc = -10;
  int run_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [5:0] exp;
    forever begin
      @(negedge clk);
      mcyc++;
      if (rst && res_valid && res_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: res_C=%0d with no result pending", res_C);
        end else begin
          exp = sb.pop_front();
          if (res_C !== exp) begin
            n_err++;
            $display("FAIL result_data: got %0d, expected %0d", res_C, exp);
          end
        end
        run_len = (last_pop_cyc == mcyc - 1) ? run_len + 1 : 1;
        last_pop_cyc = mcyc;
      end
    end
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    bit acc = 1'b0;
    in_valid = 1'b1; in_A = a; in_B = b; in_op = op;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (acc) begin
      sb.push_back(alu_fn(a, b, op));
      n_acc++;
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: command A=%0d B=%0d never accepted", a, b);
    end
  endtask

  task automatic drain();
    res_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    bit acc;
    fork
      monitor_loop();
    join_none

    rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_A = '0; in_B = '0; in_op = '0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_C", res_C, 0);
    check("rst_alu_A", alu_A, 0);
    check("rst_alu_B", alu_B, 0);
    check("rst_alu_op", alu_op_code, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_res_valid", res_valid, 0);
    end

    // Single add: latency and one-cycle result
    res_ready = 1'b1;
    send(4'd1, 4'd9, 2'd0);
    @(posedge clk); #1;
    check("single_alu_A", alu_A, 1);
    check("single_alu_B", alu_B, 9);
    check("single_alu_op", alu_op_code, 0);
    @(posedge clk); #1;
    check("single_early", res_valid, 0);
    @(posedge clk); #1;
    check("single_valid", res_valid, 1);
    check("single_C", res_C, 6'b001010);
    @(posedge clk); #1;
    check("single_one_cycle", res_valid, 0);

    // Back-to-back: one result per cycle
    send(4'd1, 4'd1, 2'd0);
    send(4'd2, 4'd3, 2'd0);
    send(4'd15, 4'd15, 2'd0);
    send(4'd7, 4'd8, 2'd0);
    repeat (6) @(posedge clk);
    #1;
    check("b2b_run", run_len, 4);
    check("b2b_empty", sb.size(), 0);

    // Backpressure: credits stop issue after RES_DEPTH, FIFO fills
    res_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(4'(i + 1), 4'(2 * i), 2'd0);
    in_valid = 1'b1; in_A = 4'd8; in_B = 4'd14; in_op = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    check("bp_issues", alu_A, RES_DEPTH);
    check("bp_res_valid", res_valid, 1);
    check("bp_pending", sb.size(), 7);
`ifdef ALU_ISSUE_STATS_EN
    check("stall_cnt", stall_cnt, 4);
`endif
    in_valid = 1'b0;
    res_ready = 1'b1;
    send(4'd8, 4'd14, 2'd0);
    drain();

    // Reset while results are pending
    res_ready = 1'b0;
    send(4'd3, 4'd4, 2'd0);
    send(4'd5, 4'd6, 2'd1);
    send(4'd9, 4'd12, 2'd2);
    repeat (5) @(posedge clk);
    #1;
    check("mid_pending", res_valid, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_alu_A", alu_A, 0);
    sb.delete();
    n_acc = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("mid_no_stale", res_valid, 0);
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_A      = 4'($urandom);
      in_B      = 4'($urandom);
      in_op     = 2'($urandom);
      res_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sb.push_back(alu_fn(in_A, in_B, in_op));
        n_acc++;
      end
      if (sb.size() < DEPTH) check("rand_in_ready", in_ready, 1);
      if (sb.size() > DEPTH + RES_DEPTH) check("rand_overfill", sb.size(), DEPTH + RES_DEPTH);
    end
    drain();
    @(posedge clk); #1;
    check("end_res_valid", res_valid, 0);
    check("end_in_ready", in_ready, 1);
`ifdef ALU_ISSUE_STATS_EN
    check("issued_cnt", issued_cnt, n_acc % 256);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
